// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  // Signed clamp value for a width-bit result: min if neg, else max.
  function automatic logic [63:0] sat_value(input int unsigned width, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (width - 32'd1);
    return neg ? msb : msb - 64'd1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple slice; exposes the carry into its MSB so the
// final slice can derive signed overflow.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub, one CHUNK slice resolved per stage with registered carry.
// Optional ADDSUB_SAT_EN clamps s to signed max/min on overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] a_in, bx_in, s_in, s_nx, s_d;
    logic             c_in, v_in, cc, cm;
    logic [CHUNK-1:0] cs;

    if (k == 0) begin : g_head
      // Subtract as a + ~b + 1: invert b once here, carry-in carries the +1.
      assign a_in  = a;
      assign bx_in = (sub == ADDSUB_SUB) ? ~b : b;
      assign c_in  = sub;
      assign v_in  = in_valid;
      assign s_in  = '0;
    end else begin : g_body
      logic unused_lo;
      assign a_in      = a_q[k-1];
      assign bx_in     = bx_q[k-1];
      assign c_in      = c_q[k-1];
      assign v_in      = vld_q[k-1];
      assign s_in      = s_q[k-1];
      assign unused_lo = ^{a_in[k*CHUNK-1:0], bx_in[k*CHUNK-1:0]};
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (a_in[k*CHUNK +: CHUNK]),
      .b_i    (bx_in[k*CHUNK +: CHUNK]),
      .cin_i  (c_in),
      .s_o    (cs),
      .cout_o (cc),
      .cmsb_o (cm)
    );

    always_comb begin
      s_nx = s_in;
      s_nx[k*CHUNK +: CHUNK] = cs;
    end

    if (k == STAGES-1) begin : g_tail
      logic ovf_d;
      assign ovf_d = cm ^ cc;
`ifdef ADDSUB_SAT_EN
      assign s_d = ovf_d ? WIDTH'(sat_value(WIDTH, a_in[WIDTH-1])) : s_nx;
`else
      assign s_d = s_nx;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             ovf_q <= 1'b0;
        else if (adv && v_in)   ovf_q <= ovf_d;
      end
    end else begin : g_mid
      assign s_d = s_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end else if (adv) begin
        vld_q[k] <= v_in;
        if (v_in) begin
          a_q[k]  <= a_in;
          bx_q[k] <= bx_in;
          s_q[k]  <= s_d;
          c_q[k]  <= cc;
        end
      end
    end
  end

  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], bx_q[STAGES-1]};

  assign out_valid = vld_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
